// File: rtl/axi_pkg.sv
// Shared AXI read-master definitions: response/burst encodings, read FSM
// states and a constant-foldable clog2 used for port and counter sizing.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR    = 2'd1,
    R     = 2'd2,
    DRAIN = 2'd3
  } rd_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_ifu_rd_master.sv
// AXI4 read-only master for instruction-fetch / I-cache line refills.
// One request at a time becomes one INCR burst; beats are passed straight
// through to the requester with backpressure. Flush aborts the fetch and the
// remaining beats are drained silently. Beat framing (rsp_last) comes from a
// local beat counter; a slave rlast that disagrees is flagged with rsp_err.
// Optional watchdog: define AXI_RD_TIMEOUT_EN to abort a stalled AR/R phase
// after TIMEOUT_CYC idle cycles with a forced error beat.
module axi_ifu_rd_master
  import axi_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int MAX_LEN     = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [clog2(MAX_LEN):0] req_len,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_last,
  output logic                    rsp_err,
  output logic [ADDR_W-1:0]       araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_W-1:0]       rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int                LEN_W     = clog2(MAX_LEN) + 1;
  localparam int                BYTE_LSB  = clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << BYTE_LSB) - 1);

  // Reject parameter sets the 8-bit arlen or the watchdog cannot represent.
  if (MAX_LEN < 1 || MAX_LEN > 256 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("axi_ifu_rd_master: unsupported MAX_LEN or TIMEOUT_CYC");
  end

  rd_state_e   state, next_state;
  logic        accept_en;
  logic        flush_seen;
  logic [7:0]  beat_cnt;
  logic [7:0]  len_m1;
  logic        counted_last;
  logic        req_hs;
  logic        timeout;

  assign arsize       = 3'(BYTE_LSB);
  assign counted_last = (beat_cnt == arlen);
  assign req_hs       = req_valid && req_ready;

  // Clamp the requested length into 1..MAX_LEN and convert to AXI beats-1.
  always_comb begin
    if (req_len == '0) begin
      len_m1 = 8'd0;
    end else if (req_len > LEN_W'(MAX_LEN)) begin
      len_m1 = 8'(MAX_LEN - 1);
    end else begin
      len_m1 = 8'(req_len) - 8'd1;
    end
  end

`ifdef AXI_RD_TIMEOUT_EN
  localparam int WD_W = clog2(TIMEOUT_CYC) + 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;
  logic            wd_kick;

  assign wd_active = (state == AR) || (state == R);
  assign wd_kick   = ((state == AR) && arvalid && arready) ||
                     ((state == R) && rvalid && rready);
  assign timeout   = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog: counts stalled AR/R cycles, cleared by any channel progress.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wd_cnt <= '0;
    end else if (!wd_active || wd_kick || timeout) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and channel outputs; R is a zero-latency pass-through.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    rsp_valid  = 1'b0;
    rsp_last   = 1'b0;
    rsp_err    = 1'b0;
    rsp_data   = '0;
    case (state)
      IDLE: begin
        req_ready = accept_en && !flush;
        if (req_valid && accept_en && !flush) next_state = AR;
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) next_state = (flush || flush_seen) ? DRAIN : R;
      end
      R: begin
        rsp_valid = rvalid;
        rready    = rsp_ready;
        rsp_data  = rdata;
        rsp_last  = rvalid && counted_last;
        rsp_err   = rvalid && ((rresp != AXI_RESP_OKAY) || (rlast != counted_last));
        if (rvalid && rsp_ready && (counted_last || rlast)) begin
          next_state = IDLE;
        end else if (flush) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        rready = 1'b1;
        if (rvalid && (counted_last || rlast)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (timeout) begin
      arvalid    = 1'b0;
      rready     = 1'b0;
      rsp_valid  = 1'b1;
      rsp_last   = 1'b1;
      rsp_err    = 1'b1;
      rsp_data   = '0;
      next_state = DRAIN;
    end
  end

  // State, request latch, flush memory and beat counter.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      accept_en  <= 1'b0;
      flush_seen <= 1'b0;
      beat_cnt   <= 8'd0;
      araddr     <= '0;
      arlen      <= 8'd0;
    end else begin
      state     <= next_state;
      accept_en <= 1'b1;
      if (state == IDLE && req_hs) begin
        araddr     <= req_addr & ADDR_MASK;
        arlen      <= len_m1;
        flush_seen <= 1'b0;
        beat_cnt   <= 8'd0;
      end
      if (state == AR) flush_seen <= flush_seen || flush;
      if ((state == R || state == DRAIN) && rvalid && rready) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_ifu_rd_master.sv
// Self-checking bench for axi_ifu_rd_master: a behavioural AXI slave drives
// AR/R, expected requester beats are queued when the slave presents them and
// popped when the DUT hands a beat to the requester.
module tb_axi_ifu_rd_master;

  logic        aclk;
  logic        areset;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
  } beat_t;

  beat_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  axi_ifu_rd_master dut (
    .aclk      (aclk),
    .areset    (areset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic check_output(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h @%0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [31:0] addr, input int b);
    return {addr, 24'h5A5A00, 8'(b)};
  endfunction

  // One refill: request, AR phase (optional delay/flush), R phase with
  // optional stall, error response, early rlast, flush or mid-burst reset.
  task automatic run_burst(input logic [31:0] addr, input int len, input int ar_delay,
                           input int flush_at, input int stall_beat, input int stall_cyc,
                           input int err_beat, input int early_last, input int flush_beat,
                           input int reset_beat);
    int    exp_len;
    int    slave_last;
    int    b;
    int    stall_left;
    int    pushed;
    bit    drain;
    bit    ar_done;
    bit    done;
    beat_t e;

    exp_len    = (len == 0) ? 1 : ((len > 8) ? 8 : len);
    slave_last = (early_last >= 0) ? early_last : exp_len - 1;
    drain      = 1'b0;
    ar_done    = 1'b0;
    done       = 1'b0;

    @(negedge aclk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = 4'(len);
    flush     = 1'b0;
    #1;
    check_output("req_ready_accept", req_ready, 1'b1);
    @(negedge aclk);
    req_valid = 1'b0;
    #1;
    check_output("araddr", araddr, addr & ~32'h7);
    check_output("arlen", arlen, 8'(exp_len - 1));
    check_output("arsize", arsize, 3'd3);

    for (int c = 0; c < 64; c++) begin
      if (c > 0) @(negedge aclk);
      arready = (c >= ar_delay);
      flush   = (c == flush_at);
      if (flush) drain = 1'b1;
      #1;
      check_output("arvalid_hold", arvalid, 1'b1);
      if (arready) begin
        ar_done = 1'b1;
        break;
      end
    end
    check_output("ar_handshake", ar_done, 1'b1);

    b          = 0;
    stall_left = stall_cyc;
    pushed     = -1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge aclk);
      arready = 1'b0;
      flush   = 1'b0;
      rvalid  = 1'b1;
      rdata   = beat_data(addr, b);
      rresp   = (b == err_beat) ? 2'b10 : 2'b00;
      rlast   = (b == slave_last);
      if (drain) begin
        rsp_ready = 1'b0;
      end else if (b == stall_beat && stall_left > 0) begin
        rsp_ready = 1'b0;
        stall_left--;
      end else begin
        rsp_ready = 1'b1;
      end
      if (!drain && b == flush_beat) flush = 1'b1;
      if (!drain && pushed != b) begin
        e.data = beat_data(addr, b);
        e.last = (b == exp_len - 1);
        e.err  = (b == err_beat) || ((b == slave_last) != (b == exp_len - 1));
        sb_q.push_back(e);
        pushed = b;
      end
      #1;
      if (b == reset_beat) begin
        areset = 1'b1;
        #1;
        check_output("rst_rsp_valid", rsp_valid, 1'b0);
        check_output("rst_rready", rready, 1'b0);
        check_output("rst_rsp_last", rsp_last, 1'b0);
        check_output("rst_rsp_err", rsp_err, 1'b0);
        check_output("rst_req_ready", req_ready, 1'b0);
        check_output("rst_arvalid", arvalid, 1'b0);
        check_output("rst_araddr", araddr, 32'h0);
        check_output("rst_arlen", arlen, 8'h0);
        sb_q.delete();
        @(negedge aclk);
        rvalid    = 1'b0;
        rlast     = 1'b0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        return;
      end
      if (drain) begin
        check_output("drain_rsp_valid", rsp_valid, 1'b0);
        check_output("drain_rready", rready, 1'b1);
        check_output("drain_req_ready", req_ready, 1'b0);
      end else begin
        check_output("rsp_valid_pass", rsp_valid, 1'b1);
        check_output("rready_pass", rready, rsp_ready);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check_output("sb_unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check_output("rsp_data", rsp_data, e.data);
          check_output("rsp_last", rsp_last, e.last);
          check_output("rsp_err", rsp_err, e.err);
        end
      end
      if (flush) drain = 1'b1;
      if (rready) begin
        if (b == exp_len - 1 || rlast) done = 1'b1;
        b++;
      end
    end
    check_output("r_complete", done, 1'b1);

    @(negedge aclk);
    rvalid    = 1'b0;
    rlast     = 1'b0;
    rresp     = 2'b00;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    #1;
    check_output("req_ready_idle", req_ready, 1'b1);
    check_output("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    areset    = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_len   = 4'd0;
    rsp_ready = 1'b0;
    arready   = 1'b0;
    rdata     = 64'h0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    rvalid    = 1'b0;

    repeat (2) @(negedge aclk);
    #1;
    check_output("reset_req_ready", req_ready, 1'b0);
    check_output("reset_arvalid", arvalid, 1'b0);
    check_output("reset_rready", rready, 1'b0);
    check_output("reset_rsp_valid", rsp_valid, 1'b0);
    check_output("reset_araddr", araddr, 32'h0);
    check_output("reset_arlen", arlen, 8'h0);
    check_output("reset_arsize", arsize, 3'd3);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    #1;
    check_output("post_reset_req_ready", req_ready, 1'b1);

    // Flush in IDLE blocks acceptance for that cycle only.
    @(negedge aclk);
    req_valid = 1'b1;
    req_addr  = 32'h1000_0000;
    req_len   = 4'd2;
    flush     = 1'b1;
    #1;
    check_output("flush_idle_req_ready", req_ready, 1'b0);
    @(negedge aclk);
    req_valid = 1'b0;
    flush     = 1'b0;
    #1;
    check_output("flush_idle_no_ar", arvalid, 1'b0);

    // addr, len, ar_delay, flush_at, stall_beat, stall_cyc, err_beat,
    // early_last, flush_beat, reset_beat
    run_burst(32'h8000_0004, 4, 0, -1, -1, 0, -1, -1, -1, -1);
    run_burst(32'h8000_0040, 4, 0, -1,  1, 3, -1, -1, -1, -1);
    run_burst(32'h8000_0080, 4, 5,  2, -1, 0, -1, -1, -1, -1);
    run_burst(32'h8000_00C0, 4, 1, -1, -1, 0,  1, -1, -1, -1);
    run_burst(32'h8000_0100, 4, 0, -1, -1, 0, -1,  1, -1, -1);
    run_burst(32'h8000_0140, 4, 2, -1, -1, 0, -1, -1,  1, -1);
    run_burst(32'h8000_0180, 12, 0, -1, 3, 2, -1, -1, -1, -1);
    run_burst(32'h8000_01C7, 0, 0, -1, -1, 0, -1, -1, -1, -1);
    run_burst(32'h8000_0200, 8, 0, -1, -1, 0, -1, -1, -1,  2);
    run_burst(32'h8000_0240, 1, 0, -1, -1, 0, -1, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
